rr_arbiter32: RTL and testbench

RR_ARBITER32 -- requirements
Module: rr_arbiter32

---
 rtl/rr_arbiter32.sv | 115 +++++++++++
 tb/tb_rr_arbiter32.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter32.sv
// 32-source round-robin arbiter with a registered grant index that is held until ack.
// Optional grant timeout is enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter32 #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] req,
  input  logic        ack,
  output logic [4:0]  grant_idx,
  output logic        grant_valid,
  output logic        timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  ptr;
  logic [4:0]  ptr_nxt;
  logic [4:0]  grant_idx_nxt;
  logic        grant_valid_nxt;
  logic [4:0]  pick_idx;
  logic        pick_found;
  logic        expire;
  logic        release_now;

  // Search upward from ptr for the first requester; the 5-bit sum wraps 31 -> 0.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr;
    for (int i = 0; i < 32; i++) begin
      if (!pick_found && req[ptr + 5'(i)]) begin
        pick_found = 1'b1;
        pick_idx   = ptr + 5'(i);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wait_cnt;

  assign expire = (state == GRANT) && !ack && (wait_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 8'd0;
      timeout  <= 1'b0;
    end else begin
      timeout <= expire;
      if (state == IDLE) begin
        wait_cnt <= 8'd0;
      end else if (!ack && !expire) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end
`else
  // TIMEOUT only matters when the timeout feature is built in.
  logic [7:0] timeout_cfg_unused;

  assign timeout_cfg_unused = 8'(TIMEOUT);
  assign expire             = 1'b0;
  assign timeout            = 1'b0;
`endif

  assign release_now = (state == GRANT) && (ack || expire);

  always_comb begin
    state_nxt       = state;
    ptr_nxt         = ptr;
    grant_idx_nxt   = grant_idx;
    grant_valid_nxt = grant_valid;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt       = GRANT;
          grant_idx_nxt   = pick_idx;
          grant_valid_nxt = 1'b1;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_nxt       = IDLE;
          grant_valid_nxt = 1'b0;
          ptr_nxt         = grant_idx + 5'd1;
        end
      end
      default: begin
        state_nxt       = IDLE;
        grant_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= 5'd0;
      grant_idx   <= 5'd0;
      grant_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      grant_idx   <= grant_idx_nxt;
      grant_valid <= grant_valid_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter32.sv
// Directed self-checking bench for rr_arbiter32; the timeout scenario runs when ARB_TIMEOUT_EN is defined.
module tb_rr_arbiter32;

`ifdef ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] req;
  logic        ack;
  logic [4:0]  grant_idx;
  logic        grant_valid;
  logic        timeout;

  int errors;
  int checks;

  rr_arbiter32 #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .ack         (ack),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 32'h0;
    ack   = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 32'hFFFF_FFFF;
    ack   = 1'b0;
    repeat (2) tick();
    checks++;
    if (grant_valid !== 1'b0 || grant_idx !== 5'd0 || timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: got valid=%b idx=%0d to=%b, expected 0/0/0",
               grant_valid, grant_idx, timeout);
    end
    req   = 32'h0;
    rst_n = 1'b1;
    ack   = 1'b1;
    tick();
    checks++;
    if (grant_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_no_req: got valid=%b, expected 0", grant_valid);
    end
    ack = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    req = 32'h0000_0001;
    tick();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 5'd0) begin
      errors++;
      $display("[TB] FAIL basic_grant: got valid=%b idx=%0d, expected 1/0", grant_valid, grant_idx);
    end
    ack = 1'b1;
    req = 32'h0;
    tick();
    ack = 1'b0;
    checks++;
    if (grant_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_release: got valid=%b, expected 0", grant_valid);
    end
    req = 32'h0000_0003;
    tick();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 5'd1) begin
      errors++;
      $display("[TB] FAIL basic_ptr_advance: got valid=%b idx=%0d, expected 1/1", grant_valid, grant_idx);
    end
    ack = 1'b1;
    req = 32'h0;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_fairness();
    do_reset();
    req = 32'hFFFF_FFFF;
    ack = 1'b1;
    for (int k = 0; k < 33; k++) begin
      tick();
      checks++;
      if (grant_valid !== 1'b1 || grant_idx !== 5'(k % 32)) begin
        errors++;
        $display("[TB] FAIL fair_grant_%0d: got valid=%b idx=%0d, expected 1/%0d",
                 k, grant_valid, grant_idx, k % 32);
      end
      tick();
      checks++;
      if (grant_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL fair_gap_%0d: got valid=%b, expected 0", k, grant_valid);
      end
    end
    ack = 1'b0;
    req = 32'h0;
  endtask

  task automatic test_wrap();
    do_reset();
    req = 32'h4000_0000;
    tick();
    checks++;
    if (grant_idx !== 5'd30 || grant_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_setup: got valid=%b idx=%0d, expected 1/30", grant_valid, grant_idx);
    end
    ack = 1'b1;
    req = 32'h0;
    tick();
    ack = 1'b0;
    req = 32'h0000_0005;
    tick();
    checks++;
    if (grant_idx !== 5'd0 || grant_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_first: got valid=%b idx=%0d, expected 1/0", grant_valid, grant_idx);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    checks++;
    if (grant_idx !== 5'd2 || grant_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_second: got valid=%b idx=%0d, expected 1/2", grant_valid, grant_idx);
    end
    ack = 1'b1;
    req = 32'h0;
    tick();
    ack = 1'b0;
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    req = 32'h0000_0008;
    tick();
    req = 32'h0;
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (grant_valid !== 1'b1 || grant_idx !== 5'd3 || timeout !== 1'b0) begin
        errors++;
        $display("[TB] FAIL to_wait_%0d: got valid=%b idx=%0d to=%b, expected 1/3/0",
                 c, grant_valid, grant_idx, timeout);
      end
      tick();
    end
    checks++;
    if (grant_valid !== 1'b0 || timeout !== 1'b1) begin
      errors++;
      $display("[TB] FAIL to_pulse: got valid=%b to=%b, expected 0/1", grant_valid, timeout);
    end
    req = 32'hFFFF_FFFF;
    tick();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 5'd4 || timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL to_next_grant: got valid=%b idx=%0d to=%b, expected 1/4/0",
               grant_valid, grant_idx, timeout);
    end
    repeat (3) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL to_ack_wins: got valid=%b to=%b, expected 0/0", grant_valid, timeout);
    end
    tick();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 5'd5 || timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL to_after_ack: got valid=%b idx=%0d to=%b, expected 1/5/0",
               grant_valid, grant_idx, timeout);
    end
    ack = 1'b1;
    req = 32'h0;
    tick();
    ack = 1'b0;
  endtask
`else
  task automatic test_hold();
    do_reset();
    req = 32'h0000_0080;
    tick();
    req = 32'h0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (grant_valid !== 1'b1 || grant_idx !== 5'd7 || timeout !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold_%0d: got valid=%b idx=%0d to=%b, expected 1/7/0",
                 c, grant_valid, grant_idx, timeout);
      end
      tick();
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (grant_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_release: got valid=%b, expected 0", grant_valid);
    end
  endtask
`endif

  task automatic test_async_reset();
    do_reset();
    req = 32'h0000_1000;
    tick();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 5'd12) begin
      errors++;
      $display("[TB] FAIL async_setup: got valid=%b idx=%0d, expected 1/12", grant_valid, grant_idx);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (grant_valid !== 1'b0 || grant_idx !== 5'd0 || timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_drop: got valid=%b idx=%0d to=%b, expected 0/0/0",
               grant_valid, grant_idx, timeout);
    end
    tick();
    rst_n = 1'b1;
    req   = 32'h0000_1000;
    tick();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 5'd12) begin
      errors++;
      $display("[TB] FAIL async_regrant: got valid=%b idx=%0d, expected 1/12", grant_valid, grant_idx);
    end
    ack = 1'b1;
    req = 32'h0;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    req    = 32'h0;
    ack    = 1'b0;
    test_reset();
    test_basic();
    test_fairness();
    test_wrap();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_hold();
`endif
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
